ppu_sprite_pattern_fetch: RTL and testbench

- Downstream consumer of the per-tile sprite selection stage.
- On each tile start, latches the two selected sprite slots (slot 0 has draw priority over slot 1) and fetches their low and high pattern-plane bytes from CHR memory.
- Composes an 8-pixel sprite line for the current tile: palette index, background-priority bit and sprite-0 flag per pixel.
- Feeds the background/sprite pixel mux and the sprite-0-hit logic.

---
 rtl/ppu_pkg.sv | 62 ++++++
 rtl/ppu_sprite_pixel_sel.sv | 60 ++++++
 rtl/ppu_sprite_pattern_fetch.sv | 142 ++++++++++++++
 tb/tb_ppu_sprite_pattern_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU sprite types, attribute bit positions and pattern addressing.
// Imported by the sprite pattern fetch stage and its pixel selector.
package ppu_pkg;

  localparam int ATTR_VFLIP = 7;
  localparam int ATTR_HFLIP = 6;
  localparam int ATTR_PRIO  = 5;

  localparam logic [13:0] PT_BASE0 = 14'h0000;
  localparam logic [13:0] PT_BASE1 = 14'h1000;

  typedef struct packed {
    logic       on;
    logic [7:0] tile;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] attr;
    logic       is0;
  } sprite_slot_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F0L,
    ST_F0H,
    ST_F1L,
    ST_F1H,
    ST_WAIT,
    ST_COMPOSE
  } fetch_state_t;

  function automatic logic [8:0] slot_r(
    sprite_slot_t s,
    logic [8:0]   crow
  );
    return crow - {1'b0, s.row};
  endfunction

  function automatic logic row_ok(
    sprite_slot_t s,
    logic [8:0]   crow
  );
    logic [8:0] r;
    r = slot_r(s, crow);
    return s.on && (r < 9'd8);
  endfunction

  function automatic logic [13:0] pat_addr(
    logic         pt,
    sprite_slot_t s,
    logic [8:0]   crow,
    logic         hi
  );
    logic [8:0]  r;
    logic [2:0]  row3;
    logic [13:0] base;
    r    = slot_r(s, crow);
    row3 = s.attr[ATTR_VFLIP] ? 3'd7 - r[2:0] : r[2:0];
    base = pt ? PT_BASE1 : PT_BASE0;
    return base | {2'b00, s.tile, hi, row3};
  endfunction

endpackage

// File: rtl/ppu_sprite_pixel_sel.sv
// Per-pixel sprite winner across two slots for one 8-pixel tile.
// Combinational; slot 0 wins over slot 1 when both are opaque.
module ppu_sprite_pixel_sel
  import ppu_pkg::*;
(
  input  sprite_slot_t s0,
  input  sprite_slot_t s1,
  input  logic [7:0]   lo0,
  input  logic [7:0]   hi0,
  input  logic [7:0]   lo1,
  input  logic [7:0]   hi1,
  input  logic [8:0]   col,
  output logic [39:0]  color,
  output logic [7:0]   behind,
  output logic [7:0]   is0
);

  function automatic logic [1:0] pix_of(
    sprite_slot_t s,
    logic [7:0]   lo,
    logic [7:0]   hi,
    logic [9:0]   x
  );
    logic [9:0] off;
    logic [2:0] b;
    off = x - {2'b00, s.col};
    b   = s.attr[ATTR_HFLIP] ? off[2:0] : 3'd7 - off[2:0];
    // Negative offsets wrap to large values and fail this test too
    if (off > 10'd7) return 2'b00;
    return {hi[b], lo[b]};
  endfunction

  logic [9:0] x;
  logic [1:0] p0;
  logic [1:0] p1;

  always_comb begin
    color  = '0;
    behind = '0;
    is0    = '0;
    x      = '0;
    p0     = '0;
    p1     = '0;
    for (int p = 0; p < 8; p++) begin
      x  = {col[8], col} + 10'(p);
      p0 = pix_of(s0, lo0, hi0, x);
      p1 = pix_of(s1, lo1, hi1, x);
      if (p0 != 2'b00) begin
        color[5*p +: 5] = {1'b1, s0.attr[1:0], p0};
        behind[p]       = s0.attr[ATTR_PRIO];
        is0[p]          = s0.is0;
      end else if (p1 != 2'b00) begin
        color[5*p +: 5] = {1'b1, s1.attr[1:0], p1};
        behind[p]       = s1.attr[ATTR_PRIO];
        is0[p]          = s1.is0;
      end
    end
  end

endmodule

// File: rtl/ppu_sprite_pattern_fetch.sv
// Sprite pattern fetch: latches two slots, reads four CHR bytes,
// then composes the registered 8-pixel sprite line for the tile.
module ppu_sprite_pattern_fetch
  import ppu_pkg::*;
#(
  parameter int CHR_AW  = 14,
  parameter int CHR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [8:0]        curr_row,
  input  logic [8:0]        curr_col,
  input  logic              spr_pt_sel,
  input  logic              s0_on,
  input  logic              s1_on,
  input  logic [7:0]        s0_tile,
  input  logic [7:0]        s1_tile,
  input  logic [7:0]        s0_row,
  input  logic [7:0]        s1_row,
  input  logic [7:0]        s0_col,
  input  logic [7:0]        s1_col,
  input  logic [7:0]        s0_attr,
  input  logic [7:0]        s1_attr,
  input  logic              s0_is0,
  input  logic              s1_is0,
  output logic [CHR_AW-1:0] chr_addr,
  input  logic [7:0]        chr_data_in,
  output logic [39:0]       pix_color,
  output logic [7:0]        pix_behind,
  output logic [7:0]        pix_is0
);

  if (CHR_LAT != 1) begin : g_lat_check
    $error("ppu_sprite_pattern_fetch: only CHR_LAT=1 is supported");
  end

  fetch_state_t state, next;
  sprite_slot_t sl0, sl1;
  logic [8:0]   row_q, col_q;
  logic         pt_q;
  logic [7:0]   lo0, hi0, lo1, hi1;
  logic [13:0]  addr;
  logic [39:0]  sel_color;
  logic [7:0]   sel_behind, sel_is0;
  logic         ok0, ok1, take;

  assign busy = (state != ST_IDLE);
  // A start coinciding with the done pulse is dropped, not deferred
  assign take = start && !done;
  assign ok0  = row_ok(sl0, row_q);
  assign ok1  = row_ok(sl1, row_q);
  assign chr_addr = CHR_AW'(addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    addr = '0;
    unique case (state)
      ST_IDLE:    if (take) next = ST_F0L;
      ST_F0L: begin
        next = ST_F0H;
        addr = pat_addr(pt_q, sl0, row_q, 1'b0);
      end
      ST_F0H: begin
        next = ST_F1L;
        addr = pat_addr(pt_q, sl0, row_q, 1'b1);
      end
      ST_F1L: begin
        next = ST_F1H;
        addr = pat_addr(pt_q, sl1, row_q, 1'b0);
      end
      ST_F1H: begin
        next = ST_WAIT;
        addr = pat_addr(pt_q, sl1, row_q, 1'b1);
      end
      ST_WAIT:    next = ST_COMPOSE;
      ST_COMPOSE: next = ST_IDLE;
      default:    next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sl0        <= '0;
      sl1        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      pt_q       <= 1'b0;
      lo0        <= '0;
      hi0        <= '0;
      lo1        <= '0;
      hi1        <= '0;
      pix_color  <= '0;
      pix_behind <= '0;
      pix_is0    <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: if (take) begin
          sl0   <= '{s0_on, s0_tile, s0_row, s0_col, s0_attr, s0_is0};
          sl1   <= '{s1_on, s1_tile, s1_row, s1_col, s1_attr, s1_is0};
          row_q <= curr_row;
          col_q <= curr_col;
          pt_q  <= spr_pt_sel;
        end
        ST_F0H:  lo0 <= ok0 ? chr_data_in : 8'h00;
        ST_F1L:  hi0 <= ok0 ? chr_data_in : 8'h00;
        ST_F1H:  lo1 <= ok1 ? chr_data_in : 8'h00;
        ST_WAIT: hi1 <= ok1 ? chr_data_in : 8'h00;
        ST_COMPOSE: begin
          pix_color  <= sel_color;
          pix_behind <= sel_behind;
          pix_is0    <= sel_is0;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  ppu_sprite_pixel_sel u_sel (
    .s0     (sl0),
    .s1     (sl1),
    .lo0    (lo0),
    .hi0    (hi0),
    .lo1    (lo1),
    .hi1    (hi1),
    .col    (col_q),
    .color  (sel_color),
    .behind (sel_behind),
    .is0    (sel_is0)
  );

endmodule

// File: tb/tb_ppu_sprite_pattern_fetch.sv
// Bench for ppu_sprite_pattern_fetch: directed tiles plus random tiles
// checked against an arithmetic model over a behavioural CHR memory.
module tb_ppu_sprite_pattern_fetch;

  typedef struct {
    bit on;
    int tile;
    int row;
    int col;
    int attr;
    bit is0;
  } tslot_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [8:0]  curr_row = '0, curr_col = '0;
  logic        spr_pt_sel = 1'b0;
  logic        s0_on = 0, s1_on = 0;
  logic [7:0]  s0_tile = 0, s1_tile = 0, s0_row = 0, s1_row = 0;
  logic [7:0]  s0_col = 0, s1_col = 0, s0_attr = 0, s1_attr = 0;
  logic        s0_is0 = 0, s1_is0 = 0;
  logic [13:0] chr_addr;
  logic [7:0]  chr_data_in = '0;
  logic [39:0] pix_color;
  logic [7:0]  pix_behind, pix_is0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [16384];
  int          exp_addr [4];
  int          log_addr [4];
  logic [39:0] exp_color;
  logic [7:0]  exp_behind, exp_is0;

  always #5 clk = ~clk;

  always @(posedge clk) chr_data_in <= mem[chr_addr];

  ppu_sprite_pattern_fetch dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .curr_row(curr_row), .curr_col(curr_col), .spr_pt_sel(spr_pt_sel),
    .s0_on(s0_on), .s1_on(s1_on), .s0_tile(s0_tile), .s1_tile(s1_tile),
    .s0_row(s0_row), .s1_row(s1_row), .s0_col(s0_col), .s1_col(s1_col),
    .s0_attr(s0_attr), .s1_attr(s1_attr), .s0_is0(s0_is0),
    .s1_is0(s1_is0), .chr_addr(chr_addr), .chr_data_in(chr_data_in),
    .pix_color(pix_color), .pix_behind(pix_behind), .pix_is0(pix_is0)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input tslot_t a, input tslot_t b,
                       input int crow, input int ccol, input int pt);
    tslot_t s [2];
    int lo [2];
    int hi [2];
    int cc, r, rr, base, x, off, bi, pix;
    bit found;
    s[0] = a;
    s[1] = b;
    cc = (ccol >= 256) ? ccol - 512 : ccol;
    for (int n = 0; n < 2; n++) begin
      r    = (crow - s[n].row) & 511;
      rr   = r & 7;
      if (s[n].attr[7]) rr = 7 - rr;
      base = pt * 4096 + s[n].tile * 16;
      exp_addr[2*n]   = base + rr;
      exp_addr[2*n+1] = base + 8 + rr;
      lo[n] = (s[n].on && r < 8) ? int'(mem[base + rr]) : 0;
      hi[n] = (s[n].on && r < 8) ? int'(mem[base + 8 + rr]) : 0;
    end
    exp_color  = '0;
    exp_behind = '0;
    exp_is0    = '0;
    for (int p = 0; p < 8; p++) begin
      x = cc + p;
      found = 0;
      for (int n = 0; n < 2; n++) begin
        off = x - s[n].col;
        if (!found && off >= 0 && off <= 7) begin
          bi  = s[n].attr[6] ? off : 7 - off;
          pix = ((hi[n] >> bi) & 1) * 2 + ((lo[n] >> bi) & 1);
          if (pix != 0) begin
            exp_color[5*p +: 5] = 5'(16 + (s[n].attr & 3) * 4 + pix);
            exp_behind[p] = s[n].attr[5];
            exp_is0[p]    = s[n].is0;
            found = 1;
          end
        end
      end
    end
  endtask

  task automatic drive(input tslot_t a, input tslot_t b,
                       input int crow, input int ccol, input int pt);
    s0_on = a.on;  s0_tile = 8'(a.tile); s0_row = 8'(a.row);
    s0_col = 8'(a.col); s0_attr = 8'(a.attr); s0_is0 = a.is0;
    s1_on = b.on;  s1_tile = 8'(b.tile); s1_row = 8'(b.row);
    s1_col = 8'(b.col); s1_attr = 8'(b.attr); s1_is0 = b.is0;
    curr_row = 9'(crow); curr_col = 9'(ccol); spr_pt_sel = pt[0];
  endtask

  task automatic scramble();
    s0_on = 1'($urandom); s1_on = 1'($urandom);
    s0_tile = 8'($urandom); s1_tile = 8'($urandom);
    s0_row = 8'($urandom); s1_row = 8'($urandom);
    s0_col = 8'($urandom); s1_col = 8'($urandom);
    s0_attr = 8'($urandom); s1_attr = 8'($urandom);
    curr_row = 9'($urandom); curr_col = 9'($urandom);
    spr_pt_sel = 1'($urandom);
  endtask

  task automatic run_tile(input string tag, input tslot_t a,
                          input tslot_t b, input int crow,
                          input int ccol, input int pt, input bit poke);
    int cyc, bsy, extra;
    model(a, b, crow, ccol, pt);
    @(negedge clk);
    drive(a, b, crow, ccol, pt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    cyc = 1;
    bsy = busy ? 1 : 0;
    log_addr[0] = int'(chr_addr);
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc <= 4) log_addr[cyc-1] = int'(chr_addr);
      if (busy) bsy++;
      start = poke && (cyc == 3);
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'd7);
    chk({tag, "_busy_cycles"}, 64'(bsy), 64'd6);
    for (int i = 0; i < 4; i++)
      chk({tag, "_addr"}, 64'(log_addr[i]), 64'(exp_addr[i]));
    chk({tag, "_color"}, 64'(pix_color), 64'(exp_color));
    chk({tag, "_behind"}, 64'(pix_behind), 64'(exp_behind));
    chk({tag, "_is0"}, 64'(pix_is0), 64'(exp_is0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_start_on_done"}, 64'(busy), 64'd0);
    if (poke) begin
      extra = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      chk({tag, "_poke_ignored"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    tslot_t a, b;
    int crow, ccol, cc;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);

    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_addr", 64'(chr_addr), 64'd0);
    chk("reset_color", 64'(pix_color), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    mem[14'h1212] = 8'hF0;
    mem[14'h121A] = 8'hCC;
    a = '{1, 8'h21, 10, 16, 8'h01, 0};
    b = '{0, 8'h22, 10, 16, 8'h00, 0};
    run_tile("basic", a, b, 12, 16, 1, 0);
    chk("basic_lo_addr", 64'(log_addr[0]), 64'h1212);
    chk("basic_hi_addr", 64'(log_addr[1]), 64'h121A);
    chk("basic_pixels", 64'(pix_color),
        64'({5'h00, 5'h00, 5'h16, 5'h16, 5'h15, 5'h15, 5'h17, 5'h17}));

    mem[14'h1217] = 8'hF0;
    mem[14'h121F] = 8'hCC;
    a = '{1, 8'h21, 10, 16, 8'hC0, 0};
    run_tile("flip", a, b, 10, 16, 1, 0);
    chk("flip_lo_addr", 64'(log_addr[0]), 64'h1217);
    chk("flip_pixels", 64'(pix_color),
        64'({5'h13, 5'h13, 5'h11, 5'h11, 5'h12, 5'h12, 5'h00, 5'h00}));

    mem[14'h0013] = 8'h0F; mem[14'h001B] = 8'h00;
    mem[14'h0023] = 8'hFF; mem[14'h002B] = 8'h00;
    a = '{1, 8'h01, 50, 16, 8'h02, 0};
    b = '{1, 8'h02, 50, 16, 8'h23, 0};
    run_tile("prio", a, b, 53, 16, 0, 1);
    chk("prio_behind", 64'(pix_behind), 64'h0F);

    mem[14'h0050] = 8'hFF; mem[14'h0058] = 8'h00;
    a = '{1, 8'h05, 100, 20, 8'h00, 1};
    b = '{0, 8'h06, 100, 16, 8'h00, 0};
    run_tile("partial", a, b, 100, 16, 0, 0);
    chk("partial_is0", 64'(pix_is0), 64'hF0);

    mem[14'h1071] = 8'hAA; mem[14'h1079] = 8'h55;
    mem[14'h1081] = 8'hFF; mem[14'h1089] = 8'hFF;
    a = '{1, 8'h07, 30, 0, 8'h01, 0};
    b = '{0, 8'h08, 30, 0, 8'h00, 1};
    run_tile("negcol", a, b, 31, 9'h1FD, 1, 0);
    chk("negcol_left", 64'(pix_color[14:0]), 64'd0);
    chk("negcol_s1_off", 64'(pix_is0), 64'd0);

    @(negedge clk);
    a = '{1, 8'h21, 10, 16, 8'h01, 0};
    b = '{1, 8'h22, 10, 16, 8'h00, 0};
    drive(a, b, 12, 16, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_addr", 64'(chr_addr), 64'd0);
    chk("midrst_color", 64'(pix_color), 64'd0);
    chk("midrst_behind", 64'(pix_behind), 64'd0);
    chk("midrst_is0", 64'(pix_is0), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int it = 0; it < 40; it++) begin
      crow = $urandom_range(0, 239);
      ccol = $urandom_range(0, 511);
      cc   = (ccol >= 256) ? ccol - 512 : ccol;
      a.on   = ($urandom_range(0, 3) != 0);
      a.tile = $urandom_range(0, 255);
      a.row  = (crow - $urandom_range(0, 9)) & 255;
      a.col  = (cc + $urandom_range(0, 14) - 7) & 255;
      a.attr = $urandom_range(0, 255);
      a.is0  = 1'($urandom);
      b.on   = ($urandom_range(0, 3) != 0);
      b.tile = $urandom_range(0, 255);
      b.row  = (crow - $urandom_range(0, 9)) & 255;
      b.col  = (cc + $urandom_range(0, 14) - 7) & 255;
      b.attr = $urandom_range(0, 255);
      b.is0  = 1'($urandom);
      run_tile("rand", a, b, crow, ccol, $urandom_range(0, 1), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
